// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: code-memory, redirect and decode-queue signals of fetch_ctrl
interface fetch_ctrl_if #(parameter int ADDR_W = 8);
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic instr_valid;
  logic [31:0] instr_out;
  logic [ADDR_W-1:0] pc_out;
  logic id_ready;
  modport master (
    output imem_addr, instr_valid, instr_out, pc_out,
    input imem_data, redirect_valid, redirect_pc, id_ready
  );
  modport slave (
    input imem_addr, instr_valid, instr_out, pc_out,
    output imem_data, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencer with 2-entry decode queue, redirect and halt; FETCH_PERF_EN adds push/stall counters
module fetch_ctrl #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input logic clk,
  input logic rst_n,
  input logic start,
  fetch_ctrl_if.master bus,
  output logic fetch_stall,
  output logic halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc, head_pc, tail_pc;
  logic [31:0] head_instr, tail_instr;
  logic [1:0] cnt;
  logic pop, space, is_halt, push;
  assign pop = bus.instr_valid & bus.id_ready;
  assign space = (cnt < 2'd2) | pop;
  assign is_halt = bus.imem_data == HALT_WORD;
  assign push = (state_q == RUN) & space & ~is_halt & ~bus.redirect_valid;
  assign fetch_stall = (state_q == RUN) & ~space;
  assign halted = state_q == HALT;
  assign bus.imem_addr = 32'(pc);
  assign bus.instr_valid = cnt != 2'd0;
  assign bus.instr_out = head_instr;
  assign bus.pc_out = head_pc;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // next state: redirect outranks the halt sentinel; start only matters in IDLE
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = start ? RUN : IDLE;
    else if (bus.redirect_valid) state_d = RUN;
    else if (state_q == RUN && space && is_halt) state_d = HALT;
  end
  // PC: redirect loads in any state, otherwise advance on each push
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= RESET_PC;
    else if (bus.redirect_valid) pc <= bus.redirect_pc;
    else if (push) pc <= pc + 1'b1;
  // queue: head is the registered output slot, tail holds the second entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      head_instr <= '0;
      head_pc <= '0;
      tail_instr <= '0;
      tail_pc <= '0;
    end else if (bus.redirect_valid) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
      if (push && (cnt == 2'd0 || (cnt == 2'd1 && pop))) begin
        head_instr <= bus.imem_data;
        head_pc <= pc;
      end else if (pop && cnt == 2'd2) begin
        head_instr <= tail_instr;
        head_pc <= tail_pc;
      end
      if (push && (cnt == 2'd2 || (cnt == 2'd1 && !pop))) begin
        tail_instr <= bus.imem_data;
        tail_pc <= pc;
      end
    end
`ifdef FETCH_PERF_EN
  // free-running push and stall counters, untouched by redirect
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + {31'd0, push};
      perf_stall_cnt <= perf_stall_cnt + {31'd0, fetch_stall};
    end
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl streaming, stall, redirect, halt, wrap and async reset
module tb_fetch_ctrl;
  logic clk = 0;
  logic rst_n = 0;
  logic start = 0;
  logic fetch_stall, halted;
  logic [31:0] mem [256];
  logic [39:0] sb [$];
  logic [39:0] exp_e;
  int n_cmp = 0;
  int n_err = 0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif
  fetch_ctrl_if #(.ADDR_W(8)) bus ();
  fetch_ctrl #(.ADDR_W(8), .RESET_PC(8'd0), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .bus(bus),
    .fetch_stall(fetch_stall),
    .halted(halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  assign bus.imem_data = mem[bus.imem_addr[7:0]];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem(input int halt_at);
    for (int i = 0; i < 256; i++) mem[i] = (i == halt_at) ? 32'hFFFF_FFFF : 32'hC0DE_0000 + 32'(i);
  endtask

  function automatic logic [39:0] ent(input int a);
    return {a[7:0], mem[a]};
  endfunction

  task automatic do_reset;
    rst_n = 0;
    start = 0;
    bus.redirect_valid = 0;
    bus.redirect_pc = 0;
    bus.id_ready = 0;
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    tick;
  endtask

  task automatic test_reset;
    do_reset;
    n_cmp++;
    if ({bus.instr_valid, halted, fetch_stall, bus.pc_out, bus.instr_out, bus.imem_addr} !== 75'd0) begin
      n_err++;
      $display("FAIL reset_state got v=%b h=%b s=%b pc=%h i=%h a=%h want all zero", bus.instr_valid, halted, fetch_stall, bus.pc_out, bus.instr_out, bus.imem_addr);
    end
`ifdef FETCH_PERF_EN
    n_cmp++;
    if ({perf_fetch_cnt, perf_stall_cnt} !== 64'd0) begin
      n_err++;
      $display("FAIL reset_perf got %0d/%0d want 0/0", perf_fetch_cnt, perf_stall_cnt);
    end
`endif
  endtask

  task automatic test_stream;
    do_reset;
    fill_mem(6);
    for (int i = 0; i < 6; i++) sb.push_back(ent(i));
    bus.id_ready = 1;
    start = 1;
    tick;
    start = 0;
    n_cmp++;
    if (bus.instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stream_latency got valid=%b want 0", bus.instr_valid);
    end
    tick;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      exp_e = sb.size() != 0 ? sb.pop_front() : 'x;
      if (bus.instr_valid !== 1'b1 || {bus.pc_out, bus.instr_out} !== exp_e) begin
        n_err++;
        $display("FAIL stream_data got v=%b %h want %h", bus.instr_valid, {bus.pc_out, bus.instr_out}, exp_e);
      end
      tick;
    end
    n_cmp++;
    if ({halted, bus.instr_valid, bus.imem_addr} !== {1'b1, 1'b0, 32'd6}) begin
      n_err++;
      $display("FAIL stream_halt got h=%b v=%b a=%0d want h=1 v=0 a=6", halted, bus.instr_valid, bus.imem_addr);
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    fill_mem(-1);
    for (int i = 0; i < 3; i++) sb.push_back(ent(i));
    start = 1;
    tick;
    start = 0;
    tick;
    tick;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({fetch_stall, bus.instr_valid, bus.pc_out, bus.instr_out, bus.imem_addr} !== {1'b1, 1'b1, 8'd0, mem[0], 32'd2}) begin
        n_err++;
        $display("FAIL bp_hold got s=%b v=%b pc=%0d i=%h a=%0d want s=1 v=1 pc=0 i=%h a=2", fetch_stall, bus.instr_valid, bus.pc_out, bus.instr_out, bus.imem_addr, mem[0]);
      end
      if (i < 2) tick;
    end
    bus.id_ready = 1;
    #1;
    n_cmp++;
    if (fetch_stall !== 1'b0) begin
      n_err++;
      $display("FAIL bp_stall_release got %b want 0", fetch_stall);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      exp_e = sb.size() != 0 ? sb.pop_front() : 'x;
      if (bus.instr_valid !== 1'b1 || {bus.pc_out, bus.instr_out} !== exp_e) begin
        n_err++;
        $display("FAIL bp_data got v=%b %h want %h", bus.instr_valid, {bus.pc_out, bus.instr_out}, exp_e);
      end
      tick;
    end
    bus.id_ready = 0;
`ifdef FETCH_PERF_EN
    n_cmp++;
    if ({perf_fetch_cnt, perf_stall_cnt} !== {32'd5, 32'd2}) begin
      n_err++;
      $display("FAIL bp_perf got %0d/%0d want 5/2", perf_fetch_cnt, perf_stall_cnt);
    end
    do_reset;
    n_cmp++;
    if ({perf_fetch_cnt, perf_stall_cnt} !== 64'd0) begin
      n_err++;
      $display("FAIL bp_perf_reset got %0d/%0d want 0/0", perf_fetch_cnt, perf_stall_cnt);
    end
`endif
  endtask

  task automatic test_redirect;
    do_reset;
    fill_mem(-1);
    sb.push_back(ent(0));
    sb.push_back(ent(40));
    start = 1;
    tick;
    start = 0;
    tick;
    tick;
    bus.id_ready = 1;
    bus.redirect_valid = 1;
    bus.redirect_pc = 8'd40;
    #1;
    if (bus.instr_valid && bus.id_ready) begin
      n_cmp++;
      exp_e = sb.size() != 0 ? sb.pop_front() : 'x;
      if ({bus.pc_out, bus.instr_out} !== exp_e) begin
        n_err++;
        $display("FAIL redir_pop got %h want %h", {bus.pc_out, bus.instr_out}, exp_e);
      end
    end
    tick;
    bus.redirect_valid = 0;
    n_cmp++;
    if ({bus.instr_valid, bus.imem_addr} !== {1'b0, 32'd40}) begin
      n_err++;
      $display("FAIL redir_flush got v=%b a=%0d want v=0 a=40", bus.instr_valid, bus.imem_addr);
    end
    tick;
    n_cmp++;
    exp_e = sb.size() != 0 ? sb.pop_front() : 'x;
    if (bus.instr_valid !== 1'b1 || {bus.pc_out, bus.instr_out} !== exp_e) begin
      n_err++;
      $display("FAIL redir_target got v=%b %h want %h", bus.instr_valid, {bus.pc_out, bus.instr_out}, exp_e);
    end
  endtask

  task automatic test_halt_drain;
    do_reset;
    fill_mem(2);
    sb.push_back(ent(0));
    sb.push_back(ent(1));
    start = 1;
    tick;
    start = 0;
    tick;
    tick;
    bus.id_ready = 1;
    #1;
    n_cmp++;
    exp_e = sb.size() != 0 ? sb.pop_front() : 'x;
    if (bus.instr_valid !== 1'b1 || {bus.pc_out, bus.instr_out} !== exp_e) begin
      n_err++;
      $display("FAIL halt_pop0 got v=%b %h want %h", bus.instr_valid, {bus.pc_out, bus.instr_out}, exp_e);
    end
    tick;
    bus.id_ready = 0;
    n_cmp++;
    if ({halted, bus.instr_valid, bus.imem_addr} !== {1'b1, 1'b1, 32'd2}) begin
      n_err++;
      $display("FAIL halt_enter got h=%b v=%b a=%0d want h=1 v=1 a=2", halted, bus.instr_valid, bus.imem_addr);
    end
    start = 1;
    tick;
    start = 0;
    tick;
    n_cmp++;
    if ({halted, bus.instr_valid, bus.imem_addr} !== {1'b1, 1'b1, 32'd2}) begin
      n_err++;
      $display("FAIL halt_start_ignored got h=%b v=%b a=%0d want h=1 v=1 a=2", halted, bus.instr_valid, bus.imem_addr);
    end
    bus.id_ready = 1;
    #1;
    n_cmp++;
    exp_e = sb.size() != 0 ? sb.pop_front() : 'x;
    if (bus.instr_valid !== 1'b1 || {bus.pc_out, bus.instr_out} !== exp_e) begin
      n_err++;
      $display("FAIL halt_drain got v=%b %h want %h", bus.instr_valid, {bus.pc_out, bus.instr_out}, exp_e);
    end
    tick;
    n_cmp++;
    if ({halted, bus.instr_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL halt_empty got h=%b v=%b want h=1 v=0", halted, bus.instr_valid);
    end
    sb.push_back(ent(0));
    bus.redirect_valid = 1;
    bus.redirect_pc = 8'd0;
    tick;
    bus.redirect_valid = 0;
    n_cmp++;
    if ({halted, bus.instr_valid, bus.imem_addr} !== {1'b0, 1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL halt_exit got h=%b v=%b a=%0d want h=0 v=0 a=0", halted, bus.instr_valid, bus.imem_addr);
    end
    tick;
    n_cmp++;
    exp_e = sb.size() != 0 ? sb.pop_front() : 'x;
    if (bus.instr_valid !== 1'b1 || {bus.pc_out, bus.instr_out} !== exp_e) begin
      n_err++;
      $display("FAIL halt_resume got v=%b %h want %h", bus.instr_valid, {bus.pc_out, bus.instr_out}, exp_e);
    end
  endtask

  task automatic test_wrap;
    do_reset;
    fill_mem(-1);
    bus.redirect_valid = 1;
    bus.redirect_pc = 8'd255;
    tick;
    bus.redirect_valid = 0;
    tick;
    tick;
    n_cmp++;
    if ({halted, bus.instr_valid, bus.imem_addr} !== {1'b0, 1'b0, 32'd255}) begin
      n_err++;
      $display("FAIL wrap_idle_redirect got h=%b v=%b a=%0d want h=0 v=0 a=255", halted, bus.instr_valid, bus.imem_addr);
    end
    sb.push_back(ent(255));
    sb.push_back(ent(0));
    sb.push_back(ent(1));
    bus.id_ready = 1;
    start = 1;
    tick;
    start = 0;
    tick;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      exp_e = sb.size() != 0 ? sb.pop_front() : 'x;
      if (bus.instr_valid !== 1'b1 || {bus.pc_out, bus.instr_out} !== exp_e) begin
        n_err++;
        $display("FAIL wrap_data got v=%b %h want %h", bus.instr_valid, {bus.pc_out, bus.instr_out}, exp_e);
      end
      tick;
    end
  endtask

  task automatic test_async_reset;
    do_reset;
    fill_mem(1);
    start = 1;
    tick;
    start = 0;
    tick;
    tick;
    n_cmp++;
    if ({halted, bus.instr_valid, bus.imem_addr} !== {1'b1, 1'b1, 32'd1}) begin
      n_err++;
      $display("FAIL async_pre got h=%b v=%b a=%0d want h=1 v=1 a=1", halted, bus.instr_valid, bus.imem_addr);
    end
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({halted, bus.instr_valid, bus.imem_addr, bus.pc_out, bus.instr_out} !== 74'd0) begin
      n_err++;
      $display("FAIL async_reset got h=%b v=%b a=%0d pc=%0d i=%h want all zero", halted, bus.instr_valid, bus.imem_addr, bus.pc_out, bus.instr_out);
    end
`ifdef FETCH_PERF_EN
    n_cmp++;
    if ({perf_fetch_cnt, perf_stall_cnt} !== 64'd0) begin
      n_err++;
      $display("FAIL async_perf got %0d/%0d want 0/0", perf_fetch_cnt, perf_stall_cnt);
    end
`endif
    @(negedge clk) rst_n = 1;
    tick;
  endtask

  initial begin
    bus.redirect_valid = 0;
    bus.redirect_pc = 0;
    bus.id_ready = 0;
    fill_mem(-1);
    test_reset;
    test_stream;
    test_backpressure;
    test_redirect;
    test_halt_drain;
    test_wrap;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer between the pipeline and the combinational, word-addressed code memory. Owns the PC and drives the memory address each cycle. Buffers fetched words in a 2-entry queue toward decode, with a valid/ready handshake. Handles redirects (jump/branch), back-pressure, and halt on a sentinel word.

Parameters:
ADDR_W, 8, PC width in words (code memory depth = 2^ADDR_W)
RESET_PC, 0, PC value loaded on reset
HALT_WORD, 32'hFFFF_FFFF, fetched word that stops sequencing

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  leave IDLE and begin fetching
imem_addr  out  32  word address to code memory; PC zero-extended
imem_data  in  32  code memory read data, combinational from imem_addr
redirect_valid  in  1  load new PC and flush the queue
redirect_pc  in  ADDR_W  redirect target
instr_valid  out  1  queue head valid
instr_out  out  32  queue head instruction
pc_out  out  ADDR_W  PC of queue head
id_ready  in  1  decode accepts head this cycle
fetch_stall  out  1  RUN state, queue full, no pop this cycle (combinational)
halted  out  1  state == HALT

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: pc=RESET_PC, state=IDLE, queue count=0, instr_valid=0, instr_out=0, pc_out=0, halted=0, fetch_stall=0.
- imem_addr = {zeros, pc} at all times.
- States: IDLE, RUN, HALT.
- IDLE:
  - No push into the queue.
  - start=1 → RUN at the next edge.
  - redirect_valid loads pc; state stays IDLE.
- RUN, per cycle:
  - pop = instr_valid & id_ready.
  - space = (count<2) | pop.
  - If space and imem_data != HALT_WORD: push {pc, imem_data}; pc <= pc+1 mod 2^ADDR_W (255 → 0 at ADDR_W=8).
  - If space and imem_data == HALT_WORD: no push; pc holds at the halt address; → HALT.
  - No space: pc holds; imem_data is ignored; fetch_stall=1.
  - Push and pop in the same cycle: count unchanged.
- HALT:
  - No fetch; the queue keeps draining through pops.
  - Exit only by redirect (→ RUN) or reset.
  - start is ignored.
- Redirect (RUN or HALT):
  - pc <= redirect_pc; queue count <= 0; no push that cycle; state → RUN.
  - instr_valid=0 in the following cycle.
  - A pop in the redirect cycle counts as delivered. All other entries are discarded.
- Latency:
  - A word addressed in cycle N is on instr_out from cycle N+1 when the queue was empty.
  - Sustained throughput is 1 instr/cycle while id_ready=1.
  - First instr_valid comes 2 cycles after start is sampled.
- Queue:
  - 2 entries, FIFO order.
  - Head is registered; instr_out/pc_out hold stable while instr_valid=1 and id_ready=0.
  - When empty, instr_out and pc_out retain their last values.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); queue contents are lost.

Optional Feature:
FETCH_PERF_EN:
- Defined:
  - Adds output perf_fetch_cnt[31:0]: +1 per push.
  - Adds output perf_stall_cnt[31:0]: +1 per cycle with fetch_stall=1.
  - Both are free-running, wrap at 2^32, reset to 0, and are not cleared by redirect.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Memory words 0..5 = distinct non-halt values, word 6 = HALT_WORD, id_ready=1; pulse start → instr_out delivers words 0..5 with pc_out 0..5 on consecutive cycles; then halted=1, instr_valid=0, pc=6.
2. Streaming with id_ready=0 for 4 cycles → queue holds words 0,1; fetch_stall=1 for the remaining stalled cycles; pc stays at 2; head stable at word 0. Release id_ready → words 0,1,2 in order with no loss or duplication.
3. Queue holding 2 entries, redirect_valid=1 with redirect_pc=40 and id_ready=1 → next cycle instr_valid=0; following cycle instr_out=mem[40], pc_out=40.
4. In HALT with 1 entry still queued: entry drains; start pulses have no effect; redirect_pc=0 → RUN, fetch resumes from word 0.
5. redirect_pc=255 with no halt word at 255 or 0 → pc_out sequence 255, 0, 1 (wrap-around).
6. Assert rst_n=0 mid-stream, asynchronously between edges → instr_valid, halted and pc clear without a clock edge. With FETCH_PERF_EN, after scenario 2 both counters show the expected push and stall counts; after reset both read 0.
